// File: rtl/clock_div.sv
// Programmable divider: clkout toggles every halfperiod clkin edges; 0 holds it low.
// Latency: registered output, new halfperiod acts on the next edge. Backpressure: none.
module clock_div #(
    parameter int WIDTH = 17
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic [WIDTH-1:0] halfperiod,
    output logic             clkout
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clkout_q, clkout_d;

    // The >= compare (rather than ==) lets a shrinking divisor end the phase
    // on the next edge instead of running the counter up to wrap.
    always_comb begin
        cnt_d    = cnt_q + ONE;
        clkout_d = clkout_q;
        if (halfperiod == '0) begin
            cnt_d    = '0;
            clkout_d = 1'b0;
        end else if (cnt_q >= (halfperiod - ONE)) begin
            cnt_d    = '0;
            clkout_d = ~clkout_q;
        end
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            clkout_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            clkout_q <= clkout_d;
        end
    end

    assign clkout = clkout_q;

endmodule

// File: tb/tb_clock_div.sv
// Randomised bench for clock_div against an edge-counting reference model.
module tb_clock_div;

    logic        clkin = 1'b0;
    logic        rst   = 1'b0;
    logic [16:0] halfperiod = '0;
    logic        clkout;

    logic        rst_w = 1'b0;
    logic [9:0]  hp_w  = '0;
    logic        clkout_w;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: edges elapsed in the current half-phase and the level.
    int   m_elapsed = 0;
    logic m_out     = 1'b0;

    always #5 clkin = ~clkin;

    clock_div #(.WIDTH(17)) dut (
        .clkin      (clkin),
        .rst        (rst),
        .halfperiod (halfperiod),
        .clkout     (clkout)
    );

    clock_div #(.WIDTH(10)) dut_w (
        .clkin      (clkin),
        .rst        (rst_w),
        .halfperiod (hp_w),
        .clkout     (clkout_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clkin rising edge: advance the model, then compare 1 ns later.
    task automatic tick(input string tag);
        int hp;
        @(posedge clkin);
        hp = int'(halfperiod);
        if (!rst || hp == 0) begin
            m_elapsed = 0;
            m_out     = 1'b0;
        end else if (m_elapsed + 1 >= hp) begin
            m_elapsed = 0;
            m_out     = ~m_out;
        end else begin
            m_elapsed = m_elapsed + 1;
        end
        #1;
        chk({tag, "_out"}, 32'(clkout), 32'(m_out));
        chk({tag, "_cnt"}, 32'(dut.cnt_q), 32'(m_elapsed));
    endtask

    // Called 1 ns after an edge: drop rst between edges and expect an immediate clear.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        chk({tag, "_arst_out"}, 32'(clkout), 32'd0);
        chk({tag, "_arst_cnt"}, 32'(dut.cnt_q), 32'd0);
        m_elapsed = 0;
        m_out     = 1'b0;
    endtask

    initial begin
        int first_rise;
        int rise_e, fall_e, max_cnt;
        logic prev;

        halfperiod = '0;
        #23;
        chk("reset_out", 32'(clkout), 32'd0);
        chk("reset_cnt", 32'(dut.cnt_q), 32'd0);
        tick("in_reset");
        rst = 1'b1;

        for (int i = 0; i < 10; i++) tick("hp0");

        halfperiod = 17'd1;
        for (int i = 0; i < 8; i++) tick("hp1");

        halfperiod = 17'd0;
        tick("hp1_off");
        halfperiod = 17'd2;
        for (int i = 0; i < 12; i++) tick("hp2");

        // Shrink from 5 to 2 mid-phase, then disable.
        halfperiod = 17'd0;
        tick("hp5_pre");
        halfperiod = 17'd5;
        for (int i = 0; i < 20 && m_elapsed != 3; i++) tick("hp5");
        chk("hp5_reach3", 32'(dut.cnt_q), 32'd3);
        halfperiod = 17'd2;
        for (int i = 0; i < 10; i++) tick("hp5to2");
        halfperiod = 17'd0;
        for (int i = 0; i < 5; i++) tick("hp2to0");

        // Reset mid-count while high, then release with 3.
        halfperiod = 17'd3;
        for (int i = 0; i < 20 && !(m_out && m_elapsed == 1); i++) tick("hp3_run");
        chk("hp3_high", 32'(clkout), 32'd1);
        async_reset("mid");
        tick("mid_held");
        rst = 1'b1;
        first_rise = 0;
        for (int e = 1; e <= 10; e++) begin
            tick("rel3");
            if (first_rise == 0 && clkout) first_rise = e;
        end
        chk("rel3_first_rise", 32'(first_rise), 32'd3);

        // Large divisor on the full-width instance: long run without any toggle.
        halfperiod = 17'd0;
        tick("big_pre");
        halfperiod = 17'h1FFFF;
        for (int i = 0; i < 3000; i++) tick("big");

        // Random divisor changes and random asynchronous resets.
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 9) == 0) begin
                async_reset("rnd");
                for (int i = 0; i < int'($urandom_range(1, 2)); i++) tick("rnd_rst");
                rst = 1'b1;
            end
            halfperiod = ($urandom_range(0, 7) == 0) ? 17'd0 : 17'($urandom_range(1, 9));
            for (int i = 0; i < int'($urandom_range(1, 20)); i++) tick("rnd");
        end

        // Maximum divisor on a 10-bit instance: toggles at edge 1023 and 2046.
        rst   = 1'b0;
        hp_w  = 10'h3FF;
        @(posedge clkin);
        #1;
        rst_w = 1'b1;
        rise_e  = 0;
        fall_e  = 0;
        max_cnt = 0;
        prev    = clkout_w;
        for (int e = 1; e <= 2100; e++) begin
            @(posedge clkin);
            #1;
            if (int'(dut_w.cnt_q) > max_cnt) max_cnt = int'(dut_w.cnt_q);
            if (!prev && clkout_w && rise_e == 0) rise_e = e;
            if (prev && !clkout_w && fall_e == 0) fall_e = e;
            prev = clkout_w;
        end
        chk("wmax_rise", 32'(rise_e), 32'd1023);
        chk("wmax_fall", 32'(fall_e), 32'd2046);
        chk("wmax_cnt", 32'(max_cnt), 32'd1022);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
